// File: rtl/jtag_ir_dr_chain.sv
// jtag_ir_dr_chain
//   IR, DR bank (BYPASS, IDCODE, optional USER) and TDO mux of the JTAG
//   debug port. Sits behind the TAP controller and consumes its decoded
//   state strobes. All state changes on the rising edge of tck_i.
//
//   Optional feature macro: JTAG_USER_EN
//     defined   - USER data register, user_q_o and user_upd_o are built.
//     undefined - INSN_USER decodes to BYPASS, user_q_o/user_upd_o tied 0,
//                 user_cap_i ignored.
//
// Ports
//   tck_i          clock
//   trst_i         synchronous active-high reset
//   tdi_i          serial data in
//   ir_shift_i     TAP in Shift-IR
//   ir_clock_i     TAP in Capture-IR or Shift-IR
//   ir_upd_i       TAP in Update-IR
//   dr_shift_i     TAP in Shift-DR
//   dr_clock_i     TAP in Capture-DR or Shift-DR
//   dr_upd_i       TAP in Update-DR
//   jtag_rst_i     TAP in Test-Logic-Reset (acts as a second sync reset)
//   irdr_select_i  1 = IR drives TDO, 0 = selected DR drives TDO
//   tdo_ena_i      TDO enable from the TAP
//   user_cap_i     word captured into USER on Capture-DR
//   tdo_o          serial data out
//   tdo_oe_o       TDO output enable
//   ir_o           held instruction
//   user_q_o       USER hold register
//   user_upd_o     one-cycle strobe, high while user_q_o shows a new value
module jtag_ir_dr_chain #(
  parameter int              IR_W        = 5,
  parameter logic [31:0]     IDCODE_VAL  = 32'h1000_0A6D,
  parameter int              USER_W      = 32,
  parameter logic [IR_W-1:0] INSN_IDCODE = IR_W'(5'h01),
  parameter logic [IR_W-1:0] INSN_USER   = IR_W'(5'h10)
) (
  input  logic              tck_i,
  input  logic              trst_i,
  input  logic              tdi_i,
  input  logic              ir_shift_i,
  input  logic              ir_clock_i,
  input  logic              ir_upd_i,
  input  logic              dr_shift_i,
  input  logic              dr_clock_i,
  input  logic              dr_upd_i,
  input  logic              jtag_rst_i,
  input  logic              irdr_select_i,
  input  logic              tdo_ena_i,
  input  logic [USER_W-1:0] user_cap_i,
  output logic              tdo_o,
  output logic              tdo_oe_o,
  output logic [IR_W-1:0]   ir_o,
  output logic [USER_W-1:0] user_q_o,
  output logic              user_upd_o
);

  logic            rst;
  logic            ir_cap;
  logic            dr_cap;
  logic [IR_W-1:0] ir_sr;
  logic [IR_W-1:0] ir_q;
  logic            bypass_sr;
  logic [31:0]     idcode_sr;
  logic            sel_idcode;
  logic            sel_user;

  // Test-Logic-Reset clears the chain exactly like the external reset.
  assign rst    = trst_i | jtag_rst_i;
  assign ir_cap = ir_clock_i & ~ir_shift_i;
  assign dr_cap = dr_clock_i & ~dr_shift_i;

  // Instruction register: shift stage plus hold stage.
  always_ff @(posedge tck_i) begin
    if (rst) begin
      ir_sr <= '0;
      ir_q  <= INSN_IDCODE;
    end else begin
      if (ir_cap)
        ir_sr <= IR_W'(2'b01);
      else if (ir_shift_i)
        ir_sr <= {tdi_i, ir_sr[IR_W-1:1]};
      if (ir_upd_i)
        ir_q <= ir_sr;
    end
  end

  assign ir_o       = ir_q;
  assign sel_idcode = (ir_q == INSN_IDCODE);

  always_ff @(posedge tck_i) begin
    if (rst) begin
      bypass_sr <= 1'b0;
    end else if (!sel_idcode && !sel_user) begin
      if (dr_cap)
        bypass_sr <= 1'b0;
      else if (dr_shift_i)
        bypass_sr <= tdi_i;
    end
  end

  always_ff @(posedge tck_i) begin
    if (rst) begin
      idcode_sr <= '0;
    end else if (sel_idcode) begin
      if (dr_cap)
        idcode_sr <= IDCODE_VAL;
      else if (dr_shift_i)
        idcode_sr <= {tdi_i, idcode_sr[31:1]};
    end
  end

`ifdef JTAG_USER_EN
  logic [USER_W-1:0] user_sr;
  logic [USER_W-1:0] user_q;
  logic              user_upd;

  assign sel_user = (ir_q == INSN_USER);

  always_ff @(posedge tck_i) begin
    if (rst) begin
      user_sr  <= '0;
      user_q   <= '0;
      user_upd <= 1'b0;
    end else begin
      user_upd <= 1'b0;
      if (sel_user) begin
        if (dr_cap)
          user_sr <= user_cap_i;
        else if (dr_shift_i)
          user_sr <= {tdi_i, user_sr[USER_W-1:1]};
        if (dr_upd_i) begin
          user_q   <= user_sr;
          user_upd <= 1'b1;
        end
      end
    end
  end

  assign user_q_o   = user_q;
  assign user_upd_o = user_upd;
`else
  logic unused_user;

  // USER opcode falls through to BYPASS; capture word is not consumed.
  assign sel_user    = 1'b0;
  assign unused_user = ^{user_cap_i, (ir_q == INSN_USER)};
  assign user_q_o    = '0;
  assign user_upd_o  = 1'b0;
`endif

  always_comb begin
    tdo_o = bypass_sr;
    if (irdr_select_i)
      tdo_o = ir_sr[0];
    else if (sel_idcode)
      tdo_o = idcode_sr[0];
`ifdef JTAG_USER_EN
    else if (sel_user)
      tdo_o = user_sr[0];
`endif
  end

  assign tdo_oe_o = tdo_ena_i;

endmodule

// File: doc/jtag_ir_dr_chain.md
# jtag_ir_dr_chain

Instruction register, data-register bank and TDO multiplexer of the JTAG debug port, sitting directly downstream of the TAP controller FSM. It consumes the FSM's decoded state strobes, shifts TDI through the IR or the DR selected by the current instruction, and drives TDO and its output enable. It provides IDCODE and BYPASS registers and one USER data register. The USER register hands a parallel word to the debug-module side and captures a status word back.

## Interface
- `IR_W`, 5: instruction register width (≥2).
- `IDCODE_VAL`, 32'h1000_0A6D: IDCODE register value; bit 0 must be 1.
- `USER_W`, 32: USER data register width.
- `INSN_IDCODE`, 5'h01: IDCODE opcode.
- `INSN_USER`, 5'h10: USER opcode.

Ports:
- `tck_i`  in  1  sole clock, all state on rising edge.
- `trst_i`  in  1  reset, synchronous, active-high.
- `tdi_i`  in  1  serial data in.
- `ir_shift_i`  in  1  FSM in Shift-IR.
- `ir_clock_i`  in  1  FSM in Capture-IR or Shift-IR.
- `ir_upd_i`  in  1  FSM in Update-IR.
- `dr_shift_i`  in  1  FSM in Shift-DR.
- `dr_clock_i`  in  1  FSM in Capture-DR or Shift-DR.
- `dr_upd_i`  in  1  FSM in Update-DR.
- `jtag_rst_i`  in  1  FSM in Test-Logic-Reset.
- `irdr_select_i`  in  1  1 = IR path to TDO, 0 = DR path.
- `tdo_ena_i`  in  1  FSM TDO enable.
- `user_cap_i`  in  USER_W  parallel word loaded into USER on Capture-DR.
- `tdo_o`  out  1  serial data out.
- `tdo_oe_o`  out  1  TDO output enable.
- `ir_o`  out  IR_W  current (held) instruction.
- `user_q_o`  out  USER_W  USER hold register.
- `user_upd_o`  out  1  one-cycle strobe when `user_q_o` is written.

## Operation
- Capture strobes are derived internally: `ir_cap = ir_clock_i & ~ir_shift_i` and `dr_cap = dr_clock_i & ~dr_shift_i`.
- **IR shift register** (`ir_sr`, IR_W):
  - On `ir_cap`, loads `{ {IR_W-2{1'b0}}, 2'b01 }`.
  - On `ir_shift_i`, loads `{tdi_i, ir_sr[IR_W-1:1]}`, LSB first.
- **IR hold** (`ir_o`): on `ir_upd_i`, `ir_o <= ir_sr`.
- **DR selection** by decode of `ir_o`:
  - INSN_IDCODE selects IDCODE (32-bit).
  - INSN_USER selects USER (USER_W bits).
  - All other opcodes, including all-ones, select BYPASS (1-bit).
- **Capture-DR** (`dr_cap`), for the selected register only:
  - BYPASS loads 0.
  - IDCODE loads `IDCODE_VAL`.
  - USER loads `user_cap_i`.
- **Shift-DR** (`dr_shift_i`): only the selected register shifts right, with `tdi_i` entering at the MSB. Unselected registers hold their value.
- **Update-DR** (`dr_upd_i`) with USER selected: `user_q_o <= user_sr` and `user_upd_o = 1` for exactly that cycle. With other instructions, update has no effect.
- **TDO mux**:
  - When `irdr_select_i` = 1, `tdo_o` = `ir_sr[0]`.
  - Otherwise `tdo_o` is bit 0 of the selected DR.
  - `tdo_oe_o = tdo_ena_i`.
  - Both are combinational from registers and inputs.
- **Reset**: when `trst_i` or `jtag_rst_i` is high at a rising edge:
  - `ir_o` resets to INSN_IDCODE.
  - `ir_sr`, BYPASS, IDCODE and USER shift registers reset to 0.
  - `user_q_o` and `user_upd_o` reset to 0.
  - Reset has priority over capture, shift and update.
- Capture, shift and update strobes are mutually exclusive (one FSM state per cycle), so no arbitration is required.

## Timing
- Reset values: `tdo_o` = 0, `tdo_oe_o` follows `tdo_ena_i`, `ir_o` = INSN_IDCODE, `user_q_o` = 0, `user_upd_o` = 0.
- The edge that leaves Capture loads the register. Each edge spent in Shift moves one bit, including the edge that exits to Exit1. An N-bit register therefore needs N edges in Shift.
- `tdo_o` shows the new LSB in the same cycle as each shift. Half-cycle retiming to falling TCK belongs to the pad stage, not this block.
- Pause/Exit states hold all shift registers.
- Reset mid-shift: the partial contents are discarded, `ir_o` returns to IDCODE, and no update strobe is issued.
- `ir_o` changes only on Update-IR, never during Shift-IR.

## Configuration
- `JTAG_USER_EN` defined: the USER register, `user_q_o` and `user_upd_o` are implemented as described.
- `JTAG_USER_EN` undefined:
  - INSN_USER decodes to BYPASS.
  - `user_q_o` is tied to 0 and `user_upd_o` is tied to 0.
  - `user_cap_i` is ignored and no USER flops exist.

## Test plan
- Assert `trst_i` for one edge, then Capture-DR plus 32 Shift-DR edges with `tdi_i` = 0 → TDO bit sequence LSB-first equals 32'h1000_0A6D.
- IR scan: shift in 5'h1F (all-ones) and update; then DR scan with `tdi_i` pattern 1,0,1,1 → `tdo_o` = 0,1,0,1 (one-bit delay) and `ir_o` = 5'h1F.
- IR scan of any value → first two TDO bits out are 1,0 (capture pattern 01).
- IR = INSN_USER, `user_cap_i` = 32'hCAFE_F00D, shift in 32'h1234_5678, then update →
  - TDO stream equals 32'hCAFE_F00D;
  - `user_q_o` = 32'h1234_5678;
  - `user_upd_o` is high for exactly one cycle.
- Mid Shift-DR of USER, assert `jtag_rst_i` for one edge → `user_q_o` unchanged at 0, `user_upd_o` never asserts, and `ir_o` = 5'h01.
- Build without `JTAG_USER_EN`, IR = 5'h10 → DR behaves as 1-bit bypass and `user_upd_o` stays 0 after Update-DR.
